yarvi_rf_bypass: RTL and testbench

//   Parametrised integer register file and RF pipeline stage for the YARVI core.

---
 rtl/yarvi_rf_bypass.sv | 110 +++++++++++
 tb/tb_yarvi_rf_bypass.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/yarvi_rf_bypass.sv
// YARVI integer register file and RF pipeline stage: captures pc/insn from decode and
// presents bypassed rs1/rs2 (and optionally rs3) operand values one cycle later.
module yarvi_rf_bypass #(
  parameter int XLEN  = 64,
  parameter int VLEN  = 64,
  parameter int NREAD = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid,
  input  logic            stall,
  input  logic [VLEN-1:0] pc,
  input  logic [31:0]     insn,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            rf_valid,
  output logic [VLEN-1:0] rf_pc,
  output logic [31:0]     rf_insn,
  output logic [XLEN-1:0] rf_rs1_val,
  output logic [XLEN-1:0] rf_rs2_val,
  output logic [XLEN-1:0] rf_rs3_val
);

  localparam int NPORT = (NREAD == 3) ? 3 : 2;

  logic [XLEN-1:0]             regs [32];
  logic [31:0]                 written_reg;
  logic                        rf_valid_reg;
  logic [VLEN-1:0]             rf_pc_reg;
  logic [31:0]                 rf_insn_reg;
  logic [NPORT-1:0][4:0]       rp_reg;
  logic [NPORT-1:0][4:0]       rp_next;
  logic [NPORT-1:0][XLEN-1:0]  rd_val;

  function automatic logic [4:0] src_field(input int port, input logic [31:0] word);
    case (port)
      0:       src_field = word[19:15];
      1:       src_field = word[24:20];
      default: src_field = word[31:27];
    endcase
  endfunction

  always_comb begin
    rp_next = '0;
    for (int i = 0; i < NPORT; i++) begin
      rp_next[i] = src_field(i, insn);
    end
  end

  // Pipeline stage: holds everything while execute stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_valid_reg <= 1'b0;
      rf_pc_reg    <= '0;
      rf_insn_reg  <= '0;
      rp_reg       <= '0;
    end else if (!stall) begin
      rf_valid_reg <= valid;
      rf_pc_reg    <= pc;
      rf_insn_reg  <= insn;
      rp_reg       <= rp_next;
    end
  end

  // Array contents are never reset; the written bitmap masks stale data,
  // so a write landing during reset is harmless.
  always_ff @(posedge clock) begin
    if (wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      written_reg <= '0;
    end else if (wb_rd != 5'd0) begin
      written_reg[wb_rd] <= 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (rp_reg[i] == 5'd0) begin
        rd_val[i] = '0;
      end else if (wb_rd == rp_reg[i]) begin
        rd_val[i] = wb_val;
      end else if (!written_reg[rp_reg[i]]) begin
        rd_val[i] = '0;
      end else begin
        rd_val[i] = regs[rp_reg[i]];
      end
    end
  end

  assign rf_valid   = rf_valid_reg;
  assign rf_pc      = rf_pc_reg;
  assign rf_insn    = rf_insn_reg;
  assign rf_rs1_val = rd_val[0];
  assign rf_rs2_val = rd_val[1];

  generate
    if (NPORT == 3) begin : gen_rs3
      assign rf_rs3_val = rd_val[NPORT-1];
    end else begin : gen_no_rs3
      assign rf_rs3_val = '0;
    end
  endgenerate

endmodule

// File: tb/tb_yarvi_rf_bypass.sv
// Directed bench for yarvi_rf_bypass: a vector table plus hand-written stall, bypass and
// reset sequences; runs a 3-read-port and a 2-read-port instance side by side.
module tb_yarvi_rf_bypass;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] insn = '0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_val = '0;

  logic        v3, v2;
  logic [63:0] pc3, pc2;
  logic [31:0] insn3, insn2;
  logic [63:0] a3, b3, c3, a2, b2, c2;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  yarvi_rf_bypass #(.XLEN(64), .VLEN(64), .NREAD(3)) dut3 (
    .clock(clock), .reset(reset), .valid(valid), .stall(stall), .pc(pc), .insn(insn),
    .wb_rd(wb_rd), .wb_val(wb_val), .rf_valid(v3), .rf_pc(pc3), .rf_insn(insn3),
    .rf_rs1_val(a3), .rf_rs2_val(b3), .rf_rs3_val(c3));

  yarvi_rf_bypass #(.XLEN(64), .VLEN(64), .NREAD(2)) dut2 (
    .clock(clock), .reset(reset), .valid(valid), .stall(stall), .pc(pc), .insn(insn),
    .wb_rd(wb_rd), .wb_val(wb_val), .rf_valid(v2), .rf_pc(pc2), .rf_insn(insn2),
    .rf_rs1_val(a2), .rf_rs2_val(b2), .rf_rs3_val(c2));

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] insn;
    logic [4:0]  wb_rd;
    logic [63:0] wb_val;
    logic        exp_valid;
    logic [63:0] exp_rs1;
    logic [63:0] exp_rs2;
    logic [63:0] exp_rs3;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] r4(input logic [4:0] rs3, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [4:0] rd);
    r4 = {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Table: each vector is driven at a negedge and checked 1 time unit after the next posedge.
    vecs[0] = '{1'b1, 64'h100, 32'h002081B3,   5'd0, 64'h0,          1'b1, 64'h0,    64'h0,  64'h0};
    vecs[1] = '{1'b1, 64'h104, r4(0, 2, 1, 4), 5'd1, 64'h1234,       1'b1, 64'h1234, 64'h0,  64'h0};
    vecs[2] = '{1'b1, 64'h108, r4(0, 0, 0, 5), 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 64'h10c, r4(1, 1, 1, 6), 5'd0, 64'h0,          1'b1, 64'h1234, 64'h1234, 64'h1234};
    vecs[4] = '{1'b0, 64'h110, r4(7, 2, 7, 8), 5'd7, 64'h77,         1'b0, 64'h77,   64'h0,  64'h77};
    vecs[5] = '{1'b1, 64'h114, r4(1, 7, 2, 9), 5'd0, 64'h0,          1'b1, 64'h0,    64'h77, 64'h1234};

    #2;
    check("reset rf_valid", {63'd0, v3}, 64'h0);
    check("reset rf_pc", pc3, 64'h0);
    check("reset rf_insn", {32'd0, insn3}, 64'h0);
    check("reset rs1", a3, 64'h0);
    check("reset rs2", b3, 64'h0);
    check("reset rs3", c3, 64'h0);

    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      valid  = vecs[i].valid;
      pc     = vecs[i].pc;
      insn   = vecs[i].insn;
      wb_rd  = vecs[i].wb_rd;
      wb_val = vecs[i].wb_val;
      step();
      check($sformatf("v%0d rf_valid", i), {63'd0, v3}, {63'd0, vecs[i].exp_valid});
      check($sformatf("v%0d rf_pc", i), pc3, vecs[i].pc);
      check($sformatf("v%0d rf_insn", i), {32'd0, insn3}, {32'd0, vecs[i].insn});
      check($sformatf("v%0d rs1", i), a3, vecs[i].exp_rs1);
      check($sformatf("v%0d rs2", i), b3, vecs[i].exp_rs2);
      check($sformatf("v%0d rs3", i), c3, vecs[i].exp_rs3);
      check($sformatf("v%0d n2 rs1", i), a2, vecs[i].exp_rs1);
      check($sformatf("v%0d n2 rs3", i), c2, 64'h0);
    end

    // Same-cycle bypass: write of x2 mid-cycle is visible before the edge, then from the array.
    @(negedge clock);
    valid = 1'b1; pc = 64'h200; insn = r4(0, 2, 3, 10); wb_rd = 5'd0; wb_val = 64'h0;
    step();
    check("byp rs2 before", b3, 64'h0);
    wb_rd = 5'd2; wb_val = 64'hBEEF;
    #1;
    check("byp rs2 comb", b3, 64'hBEEF);
    step();
    wb_rd = 5'd0; wb_val = 64'h0;
    #1;
    check("byp rs2 array", b3, 64'hBEEF);

    // Stall: new inputs ignored for 3 cycles; writeback to held rs1 (x3) still lands.
    @(negedge clock);
    stall = 1'b1; valid = 1'b0; pc = 64'h300; insn = r4(0, 0, 1, 11);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        wb_rd = 5'd3; wb_val = 64'h3333;
      end else begin
        wb_rd = 5'd0; wb_val = 64'h0;
      end
      step();
      check($sformatf("stall%0d rf_pc", c), pc3, 64'h200);
      check($sformatf("stall%0d rf_insn", c), {32'd0, insn3}, {32'd0, r4(0, 2, 3, 10)});
      check($sformatf("stall%0d rf_valid", c), {63'd0, v3}, 64'h1);
      check($sformatf("stall%0d rs1", c), a3, (c == 0) ? 64'h0 : 64'h3333);
      @(negedge clock);
    end
    wb_rd = 5'd0; wb_val = 64'h0; stall = 1'b0;
    step();
    check("unstall rf_pc", pc3, 64'h300);
    check("unstall rf_valid", {63'd0, v3}, 64'h0);
    check("unstall rs1", a3, 64'h1234);

    // Async reset mid-cycle, with a write pending across the reset edge.
    @(negedge clock);
    valid = 1'b1; pc = 64'h400; insn = r4(5, 0, 5, 12); wb_rd = 5'd5; wb_val = 64'h55;
    step();
    check("pre-rst rs1 x5", a3, 64'h55);
    wb_rd = 5'd0;
    #2;
    check("pre-rst rs1 arr", a3, 64'h55);
    reset = 1'b1;
    #1;
    check("rst rf_valid", {63'd0, v3}, 64'h0);
    check("rst rs1", a3, 64'h0);
    wb_rd = 5'd5; wb_val = 64'h99;
    step();
    check("rst held rs1", a3, 64'h0);
    @(negedge clock);
    reset = 1'b0; wb_rd = 5'd0; wb_val = 64'h0;
    step();
    check("post-rst rs1 x5", a3, 64'h0);
    check("post-rst rs3 x5", c3, 64'h0);
    @(negedge clock);
    wb_rd = 5'd5; wb_val = 64'h56;
    step();
    @(negedge clock);
    wb_rd = 5'd0; wb_val = 64'h0;
    step();
    check("rewrite rs1 x5", a3, 64'h56);
    check("rewrite rs3 x5", c3, 64'h56);
    check("rewrite n2 rs3", c2, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
